time_set_ctrl: RTL and testbench

- Front-end input controller for the clock board: debounces the five push-buttons and the quick button, and runs a field-edit FSM.
- Drives the preset bus consumed by the timekeeping core: year_d, month_d, day_d, hour_d, min_d, sec_d, week_s and mode.
- It is the write side of the preset interface whose read side loads the running time.
- Sits between the board buttons and the top-level clock module.

---
 rtl/time_set_ctrl.sv | 262 ++++++++++++++++++++++++++
 tb/tb_time_set_ctrl.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/time_set_ctrl.sv
// time_set_ctrl: debounces the clock-board buttons and runs the field-edit FSM that drives the preset bus.
// Optional macro TIME_SET_AUTOREPEAT_EN adds auto-repeat stepping on held up/down while editing.
module time_set_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned YEAR_MIN        = 2000,
  parameter int unsigned YEAR_MAX        = 2099,
  parameter int unsigned REPEAT_CYCLES   = 25000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        up,
  input  logic        down,
  input  logic        left,
  input  logic        right,
  input  logic        middle,
  input  logic        quick,
  output logic [14:0] year_d,
  output logic [3:0]  month_d,
  output logic [4:0]  day_d,
  output logic [5:0]  hour_d,
  output logic [5:0]  min_d,
  output logic [5:0]  sec_d,
  output logic [3:0]  week_s,
  output logic [3:0]  mode,
  output logic [2:0]  field
);

  localparam int unsigned NBTN    = 6;
  localparam int unsigned DB_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned B_UP    = 0;
  localparam int unsigned B_DOWN  = 1;
  localparam int unsigned B_LEFT  = 2;
  localparam int unsigned B_RIGHT = 3;
  localparam int unsigned B_MID   = 4;
  localparam int unsigned B_QUICK = 5;

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_EDIT  = 2'd1,
    S_LOAD  = 2'd2,
    S_ALARM = 2'd3
  } state_t;

  typedef struct packed {
    logic [14:0] year;
    logic [3:0]  month;
    logic [4:0]  day;
    logic [5:0]  hour;
    logic [5:0]  min;
    logic [5:0]  sec;
    logic [3:0]  week;
  } preset_t;

  localparam preset_t PRESET_RST = '{
    year: 15'd2024, month: 4'd1, day: 5'd1, hour: 6'd0,
    min: 6'd0, sec: 6'd0, week: 4'd1
  };

  logic [NBTN-1:0] raw_c;
  logic [NBTN-1:0] sync1_q, sync1_d;
  logic [NBTN-1:0] sync2_q, sync2_d;
  logic [NBTN-1:0] level_q, level_d;
  logic [NBTN-1:0] prev_q, prev_d;
  logic [NBTN-1:0] pulse_q, pulse_d;
  logic [DB_W-1:0] db_cnt_q [NBTN];
  logic [DB_W-1:0] db_cnt_d [NBTN];

  state_t          state_q, state_d;
  preset_t         cur_q, cur_d;
  preset_t         snap_q, snap_d;
  logic [2:0]      field_q, field_d;
  logic [3:0]      mode_q, mode_d;
  logic            rep_fire_c;

  assign raw_c = {quick, middle, right, left, down, up};

  function automatic logic is_leap(input logic [14:0] y);
    return (((y % 15'd4) == 15'd0) && ((y % 15'd100) != 15'd0)) || ((y % 15'd400) == 15'd0);
  endfunction

  function automatic logic [4:0] days_in_month(input logic [3:0] m, input logic [14:0] y);
    logic [4:0] d;
    case (m)
      4'd2:                    d = is_leap(y) ? 5'd29 : 5'd28;
      4'd4, 4'd6, 4'd9, 4'd11: d = 5'd30;
      default:                 d = 5'd31;
    endcase
    return d;
  endfunction

  // One wrap-around step of the selected field; day is clamped whenever month/year moved.
  function automatic preset_t step_field(input preset_t p, input logic [2:0] f, input logic inc);
    preset_t    r;
    logic [4:0] last;
    r    = p;
    last = days_in_month(p.month, p.year);
    case (f)
      3'd0: begin
        if (inc) r.year = (p.year == 15'(YEAR_MAX)) ? 15'(YEAR_MIN) : p.year + 15'd1;
        else     r.year = (p.year == 15'(YEAR_MIN)) ? 15'(YEAR_MAX) : p.year - 15'd1;
      end
      3'd1: begin
        if (inc) r.month = (p.month == 4'd12) ? 4'd1 : p.month + 4'd1;
        else     r.month = (p.month == 4'd1) ? 4'd12 : p.month - 4'd1;
      end
      3'd2: begin
        if (inc) r.day = (p.day >= last) ? 5'd1 : p.day + 5'd1;
        else     r.day = (p.day <= 5'd1) ? last : p.day - 5'd1;
      end
      3'd3: begin
        if (inc) r.hour = (p.hour == 6'd23) ? 6'd0 : p.hour + 6'd1;
        else     r.hour = (p.hour == 6'd0) ? 6'd23 : p.hour - 6'd1;
      end
      3'd4: begin
        if (inc) r.min = (p.min == 6'd59) ? 6'd0 : p.min + 6'd1;
        else     r.min = (p.min == 6'd0) ? 6'd59 : p.min - 6'd1;
      end
      3'd5: begin
        if (inc) r.sec = (p.sec == 6'd59) ? 6'd0 : p.sec + 6'd1;
        else     r.sec = (p.sec == 6'd0) ? 6'd59 : p.sec - 6'd1;
      end
      default: begin
        if (inc) r.week = (p.week == 4'd6) ? 4'd0 : p.week + 4'd1;
        else     r.week = (p.week == 4'd0) ? 4'd6 : p.week - 4'd1;
      end
    endcase
    if (r.day > days_in_month(r.month, r.year)) r.day = days_in_month(r.month, r.year);
    return r;
  endfunction

  // Synchronizer, per-button stability counter and rising-edge press pulse.
  always_comb begin
    sync1_d = raw_c;
    sync2_d = sync1_q;
    prev_d  = level_q;
    pulse_d = level_q & ~prev_q;
    level_d = level_q;
    for (int i = 0; i < NBTN; i++) begin
      db_cnt_d[i] = '0;
      if (sync2_q[i] != level_q[i]) begin
        if (db_cnt_q[i] == DB_W'(DEBOUNCE_CYCLES - 1)) level_d[i] = sync2_q[i];
        else                                           db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
      end
    end
  end

`ifdef TIME_SET_AUTOREPEAT_EN
  localparam int unsigned RP_W = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;

  logic [RP_W-1:0] rep_q, rep_d;
  logic            held_c;

  // Any press pulse (incl. a field change) or release restarts the repeat period.
  always_comb begin
    held_c     = (state_q == S_EDIT) && (level_q[B_UP] != level_q[B_DOWN]);
    rep_d      = '0;
    rep_fire_c = 1'b0;
    if (held_c && (pulse_q == '0)) begin
      if (rep_q == RP_W'(REPEAT_CYCLES - 1)) rep_fire_c = 1'b1;
      else                                   rep_d = rep_q + RP_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) rep_q <= '0;
    else     rep_q <= rep_d;
  end
`else
  logic rep_unused_c;

  // REPEAT_CYCLES has no effect in this build.
  assign rep_unused_c = (REPEAT_CYCLES != 0);
  assign rep_fire_c   = 1'b0;
`endif

  // Edit FSM: only the highest-priority pulse acts; opposing pairs cancel.
  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    snap_d  = snap_q;
    field_d = field_q;
    case (state_q)
      S_RUN: begin
        if (pulse_q[B_QUICK]) begin
          state_d = S_ALARM;
        end else if (pulse_q[B_MID]) begin
          state_d = S_EDIT;
          field_d = 3'd0;
          snap_d  = cur_q;
        end
      end
      S_EDIT: begin
        if (pulse_q[B_QUICK]) begin
          state_d = S_RUN;
          cur_d   = snap_q;
        end else if (pulse_q[B_MID]) begin
          state_d = S_LOAD;
        end else if (pulse_q[B_LEFT] || pulse_q[B_RIGHT]) begin
          if (pulse_q[B_RIGHT] && !pulse_q[B_LEFT])
            field_d = (field_q == 3'd6) ? 3'd0 : field_q + 3'd1;
          else if (pulse_q[B_LEFT] && !pulse_q[B_RIGHT])
            field_d = (field_q == 3'd0) ? 3'd6 : field_q - 3'd1;
        end else if (pulse_q[B_UP] != pulse_q[B_DOWN]) begin
          cur_d = step_field(cur_q, field_q, pulse_q[B_UP]);
        end else if (rep_fire_c) begin
          cur_d = step_field(cur_q, field_q, level_q[B_UP]);
        end
      end
      S_LOAD: begin
        state_d = S_RUN;
      end
      default: begin
        if (pulse_q[B_QUICK] || pulse_q[B_MID]) state_d = S_RUN;
      end
    endcase
    case (state_d)
      S_RUN:   mode_d = 4'd0;
      S_EDIT:  mode_d = 4'd1;
      S_LOAD:  mode_d = 4'd2;
      default: mode_d = 4'd3;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      level_q <= '0;
      prev_q  <= '0;
      pulse_q <= '0;
      for (int i = 0; i < NBTN; i++) db_cnt_q[i] <= '0;
      state_q <= S_RUN;
      cur_q   <= PRESET_RST;
      snap_q  <= PRESET_RST;
      field_q <= 3'd0;
      mode_q  <= 4'd0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      level_q <= level_d;
      prev_q  <= prev_d;
      pulse_q <= pulse_d;
      for (int i = 0; i < NBTN; i++) db_cnt_q[i] <= db_cnt_d[i];
      state_q <= state_d;
      cur_q   <= cur_d;
      snap_q  <= snap_d;
      field_q <= field_d;
      mode_q  <= mode_d;
    end
  end

  assign year_d  = cur_q.year;
  assign month_d = cur_q.month;
  assign day_d   = cur_q.day;
  assign hour_d  = cur_q.hour;
  assign min_d   = cur_q.min;
  assign sec_d   = cur_q.sec;
  assign week_s  = cur_q.week;
  assign mode    = mode_q;
  assign field   = field_q;

endmodule

// File: tb/tb_time_set_ctrl.sv
// Bench for time_set_ctrl: directed button sequences checked every cycle against a field-level model.
`timescale 1ns/1ps
module tb_time_set_ctrl;

  localparam int DB   = 16;
  localparam int YMIN = 2000;
  localparam int YMAX = 2199;
  localparam int RP   = 20;

  localparam int B_UP  = 1;
  localparam int B_DN  = 2;
  localparam int B_LT  = 4;
  localparam int B_RT  = 8;
  localparam int B_MID = 16;
  localparam int B_QK  = 32;
  localparam int B_REP = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic up = 1'b0, down = 1'b0, left = 1'b0, right = 1'b0, middle = 1'b0, quick = 1'b0;
  logic [14:0] year_d;
  logic [3:0]  month_d;
  logic [4:0]  day_d;
  logic [5:0]  hour_d, min_d, sec_d;
  logic [3:0]  week_s, mode;
  logic [2:0]  field;

  always #5 clk = ~clk;

  time_set_ctrl #(
    .DEBOUNCE_CYCLES(DB),
    .YEAR_MIN(YMIN),
    .YEAR_MAX(YMAX),
    .REPEAT_CYCLES(RP)
  ) dut (
    .clk(clk), .rst(rst),
    .up(up), .down(down), .left(left), .right(right), .middle(middle), .quick(quick),
    .year_d(year_d), .month_d(month_d), .day_d(day_d), .hour_d(hour_d),
    .min_d(min_d), .sec_d(sec_d), .week_s(week_s), .mode(mode), .field(field)
  );

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;
  bit cmp_en   = 0;
  int load_seen = 0;

  // Model state: preset values indexed by field number (year..week).
  int m_val[7];
  int m_snap[7];
  int m_mode  = 0;
  int m_field = 0;
  int ev_cyc[$];
  int ev_mask[$];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int days(input int mo, input int y);
    bit leap;
    leap = ((y % 4 == 0) && (y % 100 != 0)) || (y % 400 == 0);
    if (mo == 2) return leap ? 29 : 28;
    if (mo == 4 || mo == 6 || mo == 9 || mo == 11) return 30;
    return 31;
  endfunction

  task automatic step(input int f, input bit inc);
    int base, span;
    case (f)
      0:       begin base = YMIN; span = YMAX - YMIN + 1; end
      1:       begin base = 1;    span = 12; end
      2:       begin base = 1;    span = days(m_val[1], m_val[0]); end
      3:       begin base = 0;    span = 24; end
      6:       begin base = 0;    span = 7; end
      default: begin base = 0;    span = 60; end
    endcase
    m_val[f] = base + (m_val[f] - base + (inc ? 1 : span - 1)) % span;
    if (m_val[2] > days(m_val[1], m_val[0])) m_val[2] = days(m_val[1], m_val[0]);
  endtask

  task automatic apply(input int m);
    bit u, dn, l, r, mid, q, rp;
    u = m[0]; dn = m[1]; l = m[2]; r = m[3]; mid = m[4]; q = m[5]; rp = m[6];
    case (m_mode)
      0: begin
        if (q) m_mode = 3;
        else if (mid) begin m_mode = 1; m_field = 0; m_snap = m_val; end
      end
      1: begin
        if (q) begin m_mode = 0; m_val = m_snap; end
        else if (mid) m_mode = 2;
        else if (l || r) begin
          if (l != r) m_field = (m_field + (r ? 1 : 6)) % 7;
        end
        else if (u != dn) step(m_field, u);
        else if (rp) step(m_field, 1'b1);
      end
      3: if (q || mid) m_mode = 0;
      default: ;
    endcase
  endtask

  // Model advances on each clock; scheduled press events land on their output cycle.
  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      m_val   = '{2024, 1, 1, 0, 0, 0, 1};
      m_snap  = m_val;
      m_mode  = 0;
      m_field = 0;
      ev_cyc.delete();
      ev_mask.delete();
      cmp_en  = 1;
    end else begin
      if (m_mode == 2) m_mode = 0;
      while (ev_cyc.size() > 0 && ev_cyc[0] == cyc) begin
        void'(ev_cyc.pop_front());
        apply(ev_mask.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("year_d",  int'(year_d),  m_val[0]);
      chk("month_d", int'(month_d), m_val[1]);
      chk("day_d",   int'(day_d),   m_val[2]);
      chk("hour_d",  int'(hour_d),  m_val[3]);
      chk("min_d",   int'(min_d),   m_val[4]);
      chk("sec_d",   int'(sec_d),   m_val[5]);
      chk("week_s",  int'(week_s),  m_val[6]);
      chk("mode",    int'(mode),    m_mode);
      chk("field",   int'(field),   m_field);
      if (mode == 4'd2) load_seen++;
    end
  end

  task automatic drive(input int m);
    up = m[0]; down = m[1]; left = m[2]; right = m[3]; middle = m[4]; quick = m[5];
  endtask

  task automatic sched(input int c, input int m);
    ev_cyc.push_back(c);
    ev_mask.push_back(m);
  endtask

  // Clean press: output effect expected DB+4 edges after the first sampling edge.
  task automatic press(input int m);
    @(negedge clk);
    drive(m);
    sched(cyc + DB + 4, m);
    repeat (DB + 8) @(negedge clk);
    drive(0);
    repeat (DB + 8) @(negedge clk);
  endtask

  task automatic glitch_press(input int m);
    @(negedge clk);
    for (int g = 0; g < 3; g++) begin
      drive(m);
      repeat (3) @(negedge clk);
      drive(0);
      repeat (2) @(negedge clk);
    end
    drive(m);
    sched(cyc + DB + 4, m);
    repeat (DB + 8) @(negedge clk);
    drive(0);
    repeat (DB + 8) @(negedge clk);
  endtask

  // Hold up for 'hold' cycles; accepted level stays high for the same span.
  task automatic hold_up(input int hold);
    int c;
    @(negedge clk);
    drive(B_UP);
    c = cyc;
    sched(c + DB + 4, B_UP);
`ifdef TIME_SET_AUTOREPEAT_EN
    for (int j = 1; c + DB + 4 + RP * j <= c + hold + DB + 2; j++) sched(c + DB + 4 + RP * j, B_REP);
`endif
    repeat (hold) @(negedge clk);
    drive(0);
    repeat (DB + 8) @(negedge clk);
  endtask

  int ls;

  initial begin
    drive(0);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_year",  int'(year_d),  2024);
    chk("rst_month", int'(month_d), 1);
    chk("rst_day",   int'(day_d),   1);
    chk("rst_week",  int'(week_s),  1);
    chk("rst_mode",  int'(mode),    0);
    chk("rst_field", int'(field),   0);
    rst = 1'b0;

    glitch_press(B_MID);
    chk("enter_edit_mode", int'(mode), 1);
    chk("enter_edit_field", int'(field), 0);

    press(B_RT);
    press(B_DN);
    chk("month_wrap_down", int'(month_d), 12);
    press(B_UP);
    press(B_UP);
    chk("month_up_twice", int'(month_d), 2);

    press(B_UP);
    press(B_RT);
    press(B_DN);
    chk("day_wrap_mar31", int'(day_d), 31);
    press(B_LT);
    press(B_DN);
    chk("clamp2024_month", int'(month_d), 2);
    chk("clamp2024_day", int'(day_d), 29);

    press(B_UP);
    press(B_RT);
    press(B_UP);
    press(B_UP);
    press(B_LT);
    press(B_LT);
    press(B_DN);
    chk("year_2023", int'(year_d), 2023);
    press(B_RT);
    press(B_DN);
    chk("clamp2023_day", int'(day_d), 28);

    press(B_UP);
    press(B_RT);
    repeat (3) press(B_UP);
    chk("day_back_31", int'(day_d), 31);
    press(B_LT);
    press(B_LT);
    repeat (77) press(B_UP);
    chk("year_2100", int'(year_d), 2100);
    press(B_RT);
    press(B_DN);
    chk("clamp2100_day", int'(day_d), 28);

    press(B_RT);
    press(B_RT);
    press(B_DN);
    chk("hour_wrap_down", int'(hour_d), 23);
    press(B_UP);
    chk("hour_wrap_up", int'(hour_d), 0);
    ls = load_seen;
    press(B_MID);
    chk("load_one_cycle", load_seen - ls, 1);
    chk("after_load_mode", int'(mode), 0);
    chk("after_load_hour", int'(hour_d), 0);

    press(B_MID);
    repeat (4) press(B_RT);
    repeat (5) press(B_UP);
    chk("min_to_5", int'(min_d), 5);
    ls = load_seen;
    press(B_QK);
    chk("abort_mode", int'(mode), 0);
    chk("abort_min", int'(min_d), 0);
    chk("abort_no_load", load_seen - ls, 0);

    press(B_MID);
    repeat (4) press(B_RT);
    press(B_UP | B_DN);
    chk("updown_cancel", int'(min_d), 0);
    press(B_LT | B_RT);
    chk("leftright_cancel", int'(field), 4);
    press(B_UP | B_RT);
    chk("right_over_up_field", int'(field), 5);
    chk("right_over_up_min", int'(min_d), 0);
    press(B_LT);
    press(B_UP);
    press(B_QK | B_MID);
    chk("quick_over_mid_mode", int'(mode), 0);
    chk("quick_over_mid_min", int'(min_d), 0);

    press(B_QK);
    chk("alarm_mode", int'(mode), 3);
    press(B_UP);
    chk("alarm_up_ignored", int'(year_d), 2100);
    press(B_MID);
    chk("alarm_exit", int'(mode), 0);

    press(B_MID);
    press(B_LT);
    chk("field_wrap_left", int'(field), 6);
    press(B_UP);
    chk("week_up", int'(week_s), 2);
    press(B_LT);
    hold_up(65);
`ifdef TIME_SET_AUTOREPEAT_EN
    chk("sec_autorepeat", int'(sec_d), 4);
`else
    chk("sec_single_step", int'(sec_d), 1);
`endif
    press(B_MID);

    press(B_MID);
    press(B_UP);
    chk("year_2101", int'(year_d), 2101);
    ls = load_seen;
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("midedit_rst_year", int'(year_d), 2024);
    chk("midedit_rst_mode", int'(mode), 0);
    chk("midedit_rst_no_load", load_seen - ls, 0);

    repeat (4) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
